mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Parametrised multi-cycle successor to the single-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks, driving datapath enables and a request/ready handshake to a shared instruction/data memory. It sits between the instruction register (opcode/func inputs) and the multi-cycle datapath. Generalisations over the single-cycle decoder:

- variable memory latency;
- a wait-timeout guard;
- optional jump support;
- illegal-opcode reporting.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum cycles waiting for `mem_ready` before timeout. Legal range 1..255.
- `SUPPORT_JUMP`, default 1: when 0, `j` (000010) is treated as illegal.
- `clk` in 1: rising-edge clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `Opcode` in 6: `IR[31:26]`.
- `Func` in 6: `IR[5:0]`.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write when `mem_req`=1.
- `IorD` out 1: 0 = PC address, 1 = ALUOut address.
- `IRWrite` out 1: load the instruction register.
- `PCWrite` out 1: unconditional PC load.
- `Branch` out 1: PC load if ALU zero.
- `PCSource` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `ALUOp` out 6: ALU function code (func encoding).
- `RegDst` out 1: 1 = rd, 0 = rt.
- `MUX_MemToReg` out 1: 1 = MDR, 0 = ALUOut.
- `RegWrite` out 1: register-file write.
- `state` out 4: current state code, for debug.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `timeout` out 1: one-cycle pulse on memory wait expiry.

## Operation
- **State codes:** FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_WB=10. Codes 11..15 are unreachable and recover to FETCH.
- **FETCH:**
  - Drives `mem_req`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=100000.
  - On `mem_ready`: `IRWrite`=1 and `PCWrite`=1 in that same cycle, then → DECODE.
- **DECODE:** `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=100000 (branch target). Next state by `Opcode`:
  - 000000 → EXEC.
  - 100011, 101011 → MEM_ADDR.
  - 000100 → BRANCH.
  - 001000 → EXEC.
  - 000010 → JUMP when `SUPPORT_JUMP`=1.
  - Any other opcode: `illegal`=1 this cycle, → FETCH.
- **MEM_ADDR:** `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=100000. lw → MEM_READ; sw → MEM_WRITE.
- **MEM_READ:** `mem_req`=1, `IorD`=1. On `mem_ready` → MEM_WB.
- **MEM_WB:** `RegWrite`=1, `RegDst`=0, `MUX_MemToReg`=1. → FETCH.
- **MEM_WRITE:** `mem_req`=1, `mem_we`=1, `IorD`=1. On `mem_ready` → FETCH.
- **EXEC:** `ALUSrcA`=1.
  - R-type: `ALUSrcB`=00, `ALUOp`=`Func`, → R_WB.
  - addi: `ALUSrcB`=10, `ALUOp`=100000, → ADDI_WB.
- **R_WB:** `RegWrite`=1, `RegDst`=1, `MUX_MemToReg`=0. → FETCH.
- **ADDI_WB:** `RegWrite`=1, `RegDst`=0, `MUX_MemToReg`=0. → FETCH.
- **BRANCH:** `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=100010, `Branch`=1, `PCSource`=01. → FETCH.
- **JUMP:** `PCWrite`=1, `PCSource`=10. → FETCH.
- **Defaults:** every output not listed for a state is 0.
- **Opcode sampling:** `Opcode` and `Func` are sampled only in DECODE and EXEC (the IR is stable there), and in MEM_ADDR to choose MEM_READ vs MEM_WRITE.
- **Wait counter:**
  - An 8-bit counter clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - It increments each cycle in those states while `mem_ready`=0.
  - When the count equals `MEM_WAIT_MAX` with `mem_ready`=0: `timeout`=1 for one cycle, `mem_req` stays asserted that cycle, → FETCH with the counter cleared.
  - If `mem_ready`=1 on the same cycle the count reaches max, `mem_ready` wins: no timeout, normal transition.

## Timing
- **Reset:** `rst`=1 asynchronously forces state=FETCH, counter=0, `illegal`=0, `timeout`=0. Combinational outputs then take their FETCH values (`mem_req`=1, `IorD`=0, `ALUSrcB`=01, `ALUOp`=100000, all others 0).
- **Release:** FSM advances on the first rising edge after `rst` deasserts.
- **Reset mid-access:** state is abandoned immediately. `mem_we` drops combinationally and no write-back occurs.
- **Output decoding:** all datapath outputs are pure decodes of `state`, plus `Opcode`/`Func` in EXEC and `mem_ready` in FETCH. `illegal` and `timeout` are decoded from state/inputs in the cycle the condition holds.
- **Latency with zero-wait memory** (`mem_ready` high on first request cycle):
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
- **Wait states:** each cycle `mem_ready` is low in a memory state adds one cycle.
- **Ignored `mem_ready`:** high outside FETCH/MEM_READ/MEM_WRITE has no effect.

## Test plan
- Assert `rst` mid-MEM_WRITE with `mem_ready`=0 → `state`=0 and `mem_we`=0 immediately; after release, FETCH `mem_req`=1.
- R-type with `Func`=100000, zero-wait memory → states 0,1,6,7,0.
  - `ALUOp`=100000 in EXEC.
  - `RegWrite`=1 and `RegDst`=1 only in R_WB.
- lw (100011) with `mem_ready` delayed 3 cycles in MEM_READ → states 0,1,2,3,3,3,3,4,0.
  - `IorD`=1 throughout MEM_READ.
  - `MUX_MemToReg`=1 in MEM_WB.
- sw (101011), then beq (000100) → sw path 0,1,2,5,0 with `mem_we`=1 in MEM_WRITE only; beq path 0,1,8 with `Branch`=1 and `ALUOp`=100010.
- Opcode 111111, then j with `SUPPORT_JUMP`=0 → `illegal` pulses once each; both return to FETCH on the cycle after DECODE.
- `MEM_WAIT_MAX`=4, `mem_ready` held 0 in FETCH → `timeout` pulses after 4 wait cycles, then FETCH restarts.
  - Repeat with `mem_ready`=1 on that same cycle → no timeout, → DECODE.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back
// sequencing with a memory request/ready handshake and wait timeout.
module mips_multicycle_control #(
    parameter int MEM_WAIT_MAX = 15,
    parameter bit SUPPORT_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [5:0] ALUOp,
    output logic       RegDst,
    output logic       MUX_MemToReg,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC      = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_WB   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t     st_q, st_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_state;
    logic       expire;

    assign state     = st_q;
    assign mem_state = (st_q == FETCH) || (st_q == MEM_READ)
                    || (st_q == MEM_WRITE);
    assign expire    = mem_state && !mem_ready && (cnt_q == WAIT_MAX);
    // Counter is zero outside memory states, so entering one starts at 0
    assign cnt_d     = (mem_state && !mem_ready && !expire)
                     ? cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= FETCH;
            cnt_q <= 8'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d         = st_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        Branch       = 1'b0;
        PCSource     = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 6'b000000;
        RegDst       = 1'b0;
        MUX_MemToReg = 1'b0;
        RegWrite     = 1'b0;
        illegal      = 1'b0;
        timeout      = expire;
        case (st_q)
            FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = FN_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) st_d = DECODE;
                else if (expire) st_d = FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = FN_ADD;
                if (Opcode == OP_RTYPE || Opcode == OP_ADDI)
                    st_d = EXEC;
                else if (Opcode == OP_LW || Opcode == OP_SW)
                    st_d = MEM_ADDR;
                else if (Opcode == OP_BEQ)
                    st_d = BRANCH;
                else if (Opcode == OP_J && SUPPORT_JUMP)
                    st_d = JUMP;
                else begin
                    illegal = 1'b1;
                    st_d    = FETCH;
                end
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = FN_ADD;
                st_d    = (Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) st_d = MEM_WB;
                else if (expire) st_d = FETCH;
            end
            MEM_WB: begin
                RegWrite     = 1'b1;
                MUX_MemToReg = 1'b1;
                st_d         = FETCH;
            end
            MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                IorD    = 1'b1;
                if (mem_ready || expire) st_d = FETCH;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                if (Opcode == OP_RTYPE) begin
                    ALUSrcB = 2'b00;
                    ALUOp   = Func;
                    st_d    = R_WB;
                end else begin
                    ALUSrcB = 2'b10;
                    ALUOp   = FN_ADD;
                    st_d    = ADDI_WB;
                end
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                st_d     = FETCH;
            end
            ADDI_WB: begin
                RegWrite = 1'b1;
                st_d     = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = FN_SUB;
                Branch   = 1'b1;
                PCSource = 2'b01;
                st_d     = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                st_d     = FETCH;
            end
            default: st_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Random instruction traces for the multi-cycle control FSM, checked
// cycle by cycle against expected state/output sequences.
module tb_mips_multicycle_control;

    localparam int WMAX = 4;
    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3;
    localparam int K_BEQ = 4, K_J = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = '0, Func = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, IorD, IRWrite, PCWrite, Branch;
    logic [1:0] PCSource, ALUSrcB;
    logic       ALUSrcA, RegDst, MUX_MemToReg, RegWrite;
    logic [5:0] ALUOp;
    logic [3:0] state;
    logic       illegal, timeout;

    logic       rst_b = 1'b1;
    logic       rdy_b = 1'b1;
    logic [5:0] op_b = 6'b000010;
    logic [5:0] fn_b = '0;
    logic       req_b, we_b, iord_b, irw_b, pcw_b, br_b;
    logic [1:0] pcs_b, srcb_b;
    logic       srca_b, rdst_b, m2r_b, rw_b;
    logic [5:0] aluop_b;
    logic [3:0] state_b;
    logic       illegal_b, timeout_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_WAIT_MAX(WMAX), .SUPPORT_JUMP(1'b1)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Func(Func),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .MUX_MemToReg(MUX_MemToReg), .RegWrite(RegWrite),
        .state(state), .illegal(illegal), .timeout(timeout)
    );

    mips_multicycle_control #(.MEM_WAIT_MAX(WMAX), .SUPPORT_JUMP(1'b0)) dut_nj (
        .clk(clk), .rst(rst_b), .Opcode(op_b), .Func(fn_b),
        .mem_ready(rdy_b), .mem_req(req_b), .mem_we(we_b),
        .IorD(iord_b), .IRWrite(irw_b), .PCWrite(pcw_b),
        .Branch(br_b), .PCSource(pcs_b), .ALUSrcA(srca_b),
        .ALUSrcB(srcb_b), .ALUOp(aluop_b), .RegDst(rdst_b),
        .MUX_MemToReg(m2r_b), .RegWrite(rw_b),
        .state(state_b), .illegal(illegal_b), .timeout(timeout_b)
    );

    typedef struct {
        int st;
        bit rdy;
        bit tmo;
        bit ill;
    } cyc_t;

    cyc_t trace[$];
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Outputs expected in each spec state, packed in port order
    function automatic logic [21:0] exp_out(input cyc_t e, input bit is_r,
                                            input logic [5:0] f);
        logic req, we, iord, irw, pcw, br, srca, rdst, m2r, rw;
        logic [1:0] pcs, srcb;
        logic [5:0] op;
        {req, we, iord, irw, pcw, br, srca, rdst, m2r, rw} = '0;
        pcs = 2'd0; srcb = 2'd0; op = 6'd0;
        if (e.st == 0) begin
            req = 1; srcb = 2'd1; op = 6'd32; irw = e.rdy; pcw = e.rdy;
        end else if (e.st == 1) begin
            srcb = 2'd3; op = 6'd32;
        end else if (e.st == 2) begin
            srca = 1; srcb = 2'd2; op = 6'd32;
        end else if (e.st == 3) begin
            req = 1; iord = 1;
        end else if (e.st == 4) begin
            rw = 1; m2r = 1;
        end else if (e.st == 5) begin
            req = 1; we = 1; iord = 1;
        end else if (e.st == 6) begin
            srca = 1;
            srcb = is_r ? 2'd0 : 2'd2;
            op   = is_r ? f : 6'd32;
        end else if (e.st == 7) begin
            rw = 1; rdst = 1;
        end else if (e.st == 8) begin
            srca = 1; op = 6'd34; br = 1; pcs = 2'd1;
        end else if (e.st == 9) begin
            pcw = 1; pcs = 2'd2;
        end else if (e.st == 10) begin
            rw = 1;
        end
        return {req, we, iord, irw, pcw, br, pcs, srca, srcb, op,
                rdst, m2r, rw, e.ill, e.tmo};
    endfunction

    function automatic logic [21:0] obs_out();
        return {mem_req, mem_we, IorD, IRWrite, PCWrite, Branch, PCSource,
                ALUSrcA, ALUSrcB, ALUOp, RegDst, MUX_MemToReg, RegWrite,
                illegal, timeout};
    endfunction

    function automatic void push(input int st, input bit rdy,
                                 input bit tmo, input bit ill);
        cyc_t e;
        e.st = st; e.rdy = rdy; e.tmo = tmo; e.ill = ill;
        trace.push_back(e);
    endfunction

    // w cycles of mem_ready low before the access completes
    function automatic bit mem_phase(input int st, input int w);
        for (int k = 0; k <= WMAX; k++) begin
            if (k == w) begin
                push(st, 1, 0, 0);
                return 1;
            end else if (k == WMAX) begin
                push(st, 0, 1, 0);
                return 0;
            end
            push(st, 0, 0, 0);
        end
        return 0;
    endfunction

    function automatic void build(input int kind, input int wf,
                                  input int wm);
        trace.delete();
        if (!mem_phase(0, wf)) return;
        push(1, 1'($urandom), 0, kind == K_ILL);
        case (kind)
            K_R:    begin push(6, 1'($urandom), 0, 0);
                          push(7, 1'($urandom), 0, 0); end
            K_ADDI: begin push(6, 1'($urandom), 0, 0);
                          push(10, 1'($urandom), 0, 0); end
            K_LW: begin
                push(2, 1'($urandom), 0, 0);
                if (mem_phase(3, wm)) push(4, 1'($urandom), 0, 0);
            end
            K_SW: begin
                push(2, 1'($urandom), 0, 0);
                void'(mem_phase(5, wm));
            end
            K_BEQ: push(8, 1'($urandom), 0, 0);
            K_J:   push(9, 1'($urandom), 0, 0);
            default: ;
        endcase
    endfunction

    function automatic logic [5:0] op_of(input int kind);
        logic [5:0] o;
        case (kind)
            K_R:    return 6'b000000;
            K_ADDI: return 6'b001000;
            K_LW:   return 6'b100011;
            K_SW:   return 6'b101011;
            K_BEQ:  return 6'b000100;
            K_J:    return 6'b000010;
            default: begin
                do o = 6'($urandom);
                while (o inside {6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd2});
                return o;
            end
        endcase
    endfunction

    task automatic run_trace(input logic [5:0] op, input logic [5:0] f);
        foreach (trace[i]) begin
            @(negedge clk);
            mem_ready = trace[i].rdy;
            Opcode = op;
            Func = f;
            #1;
            cyc++;
            check($sformatf("state c%0d", cyc), 32'(state),
                  32'(trace[i].st));
            check($sformatf("outs c%0d st%0d", cyc, trace[i].st),
                  32'(obs_out()),
                  32'(exp_out(trace[i], op == 6'd0, f)));
        end
    endtask

    task automatic run_instr(input int kind, input logic [5:0] f,
                             input int wf, input int wm);
        build(kind, wf, wm);
        run_trace(op_of(kind), f);
    endtask

    initial begin
        cyc_t r;
        r.st = 0; r.rdy = 0; r.tmo = 0; r.ill = 0;
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset outs", 32'(obs_out()), 32'(exp_out(r, 0, '0)));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_instr(K_R, 6'b100000, 0, 0);
        run_instr(K_LW, 6'd0, 0, 3);
        run_instr(K_SW, 6'd0, 0, 0);
        run_instr(K_BEQ, 6'd0, 0, 0);
        run_instr(K_ILL, 6'd0, 0, 0);
        run_instr(K_J, 6'd0, 0, 0);
        run_instr(K_R, 6'd0, WMAX + 1, 0);
        run_instr(K_ADDI, 6'd0, WMAX, 0);
        run_instr(K_LW, 6'd0, 1, WMAX + 1);
        run_instr(K_SW, 6'd0, 2, WMAX + 1);

        // Reset while a store is waiting on memory
        trace.delete();
        push(0, 1, 0, 0);
        push(1, 0, 0, 0);
        push(2, 0, 0, 0);
        push(5, 0, 0, 0);
        run_trace(6'b101011, 6'd0);
        rst = 1'b1;
        #1;
        check("rst mid-write state", 32'(state), 32'd0);
        check("rst mid-write mem_we", 32'(mem_we), 32'd0);
        check("rst mid-write mem_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            int kind, wf, wm;
            kind = $urandom_range(0, 6);
            wf = ($urandom_range(0, 7) == 0) ? WMAX + 1
                                             : $urandom_range(0, WMAX);
            wm = ($urandom_range(0, 7) == 0) ? WMAX + 1
                                             : $urandom_range(0, WMAX);
            run_instr(kind, 6'($urandom), wf, wm);
        end

        // Jump disabled: j must be flagged illegal and return to FETCH
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk); #1;
        check("nj fetch", 32'(state_b), 32'd0);
        @(negedge clk); #1;
        check("nj decode", 32'(state_b), 32'd1);
        check("nj illegal", 32'(illegal_b), 32'd1);
        @(negedge clk); #1;
        check("nj back", 32'(state_b), 32'd0);
        check("nj ill clr", 32'(illegal_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
